hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the 5-stage RISC-V core. It sits beside the ID/EX pipeline register and consumes what that register's read side presents to EX: destination register and memory-read flag. From these, plus the ID-stage source registers, EX branch redirect and MEM-stage data-memory handshake, it drives the enable and flush inputs of PC, IF/ID, ID/EX and EX/MEM. Load-use hazards become one-cycle bubbles, taken branches squash the wrong-path instructions, and data-memory waits freeze the pipeline.

## Interface
Parameters:
- FLUSH_CYCLES, 1, cycles the flushes stay asserted per taken branch (legal range 1..15)
- CNT_W, 16, width of the stall statistics counter

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- idRs1, idRs2  in  5  source registers of the instruction in ID
- idUsesRs1, idUsesRs2  in  1  the ID instruction actually reads that source
- exMemRead  in  1  ID/EX read side: instruction in EX is a load
- exRd  in  5  ID/EX read side: destination of the instruction in EX
- branchTaken  in  1  EX resolved a taken branch or jump this cycle
- dmemReq  in  1  MEM stage has an outstanding data-memory access
- dmemReady  in  1  data memory completes the access this cycle
- pcEn  out  1  PC update enable
- ifidEn, idexEn, exmemEn  out  1  pipeline register enables
- ifidFlush, idexFlush  out  1  synchronous clear of IF/ID and ID/EX (inserts a bubble)
- stallCount  out  CNT_W  saturating count of cycles with pcEn=0
- state  out  2  FSM state, for debug

## Operation
- State register: RUN=0, FLUSH=1, MEM_WAIT=2. Register flushLeft is 4 bits.
- freeze = dmemReq & !dmemReady. loadUse = exMemRead & exRd!=0 & ((idUsesRs1 & idRs1==exRd) | (idUsesRs2 & idRs2==exRd)).
- Outputs are Mealy. Priority is freeze > branch > loadUse.
- freeze, any state: all four enables 0, both flushes 0. Next state is MEM_WAIT. flushLeft holds.
- Not frozen, in RUN or MEM_WAIT, branchTaken=1: all enables 1, ifidFlush=idexFlush=1.
  - If FLUSH_CYCLES>1: next state FLUSH, flushLeft=FLUSH_CYCLES-1.
  - Otherwise next state RUN.
- Not frozen, in FLUSH: all enables 1, both flushes 1. loadUse and branchTaken are ignored because only squashed instructions are present.
  - flushLeft decrements.
  - Next state is RUN when flushLeft becomes 0, otherwise FLUSH.
- Not frozen, no branch, RUN or MEM_WAIT, loadUse=1: pcEn=0, ifidEn=0, idexFlush=1, idexEn=1, exmemEn=1, ifidFlush=0. Next state RUN.
- Otherwise all enables 1, flushes 0. Next state RUN.
- Leaving MEM_WAIT: go to FLUSH if flushLeft!=0, else RUN; then apply the rules above in the same cycle.
- stallCount increments on every clock edge where pcEn=0, reset excluded. It saturates at 2^CNT_W-1 and never wraps.

## Timing
- Reset, asynchronous: state=RUN, flushLeft=0, stallCount=0.
- While rst=1: all enables 0, both flushes 0, state output 0.
- Reset mid-stall or mid-flush abandons the stall or flush outright; nothing resumes after reset.
- Load-use: hazard seen in cycle t. The bubble is in ID/EX at t+1, with the dependent instruction still in IF/ID. loadUse is then 0 and the pipeline proceeds. Exactly one stall cycle per load-use.
- Branch: flushes are asserted in cycle t and the following FLUSH_CYCLES-1 unfrozen cycles. pcEn=1 at t so the PC loads the target.
- Freeze holds every stage for exactly the cycles where dmemReq&!dmemReady. Progress resumes in the dmemReady cycle with zero extra latency.
- A branchTaken arriving during a freeze is held by the frozen EX stage and is acted on in the first unfrozen cycle.
- exRd=0 never causes a stall.

## Structure
- Package riscv_pipe_pkg holds:
  - state encoding constants ST_RUN, ST_FLUSH, ST_MEM_WAIT
  - REG_ZERO = 5'd0
  - register-index width constant 5
- Sub-module hazard_match: combinational loadUse comparator (exMemRead, exRd, idRs*, idUsesRs*).
- The FSM, flushLeft and stallCount live in hazard_ctrl.

## Test plan
- Load-use: exMemRead=1, exRd=5, idRs1=5, idUsesRs1=1 for one cycle, then exMemRead=0. Required: pcEn=0, ifidEn=0, idexFlush=1 for exactly one cycle; stallCount=1.
- exRd=0 with idRs1=0, idUsesRs1=1, exMemRead=1: no stall, stallCount stays 0. idUsesRs2=0 with idRs2 matching exRd: no stall.
- FLUSH_CYCLES=3, branchTaken pulse: ifidFlush=idexFlush=1 for 3 cycles, state sequence RUN→FLUSH→FLUSH→RUN; a concurrent loadUse is ignored.
- dmemReq=1, dmemReady=0 for 4 cycles, then ready, with branchTaken=1 throughout:
  - all enables 0 for 4 cycles, state=MEM_WAIT
  - flush begins in the ready cycle
  - stallCount=4
- Freeze during FLUSH (FLUSH_CYCLES=3, freeze in the 2nd flush cycle): flushLeft is held, FLUSH resumes afterwards, total flush cycles = 3.
- CNT_W=4, hold freeze 20 cycles: stallCount saturates at 15. Asynchronous rst pulse mid-freeze: outputs go to reset values immediately, stallCount=0.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pipe_pkg
// Description : Shared constants for the 5-stage pipeline hazard logic:
//               hazard FSM state encoding, register-index width and the
//               hard-wired zero register index.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pipe_pkg;

    // Width of a register-file index (x0..x31)
    localparam int REG_IDX_W = 5;

    // x0 is hard-wired to zero, so it can never carry a load-use dependency
    localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

    // Hazard controller state encoding
    localparam int         STATE_W     = 2;
    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_FLUSH    = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;

endpackage
`default_nettype wire

// File: rtl/hazard_match.sv
`default_nettype none
// ============================================================================
// Module      : hazard_match
// Description : Combinational load-use detector. Flags when the instruction
//               in EX is a load whose destination is read by the instruction
//               currently in ID.
// Ports       : exMemRead, exRd          - ID/EX read side (load flag, dest)
//               idRs1/2, idUsesRs1/2     - ID-stage sources and use flags
//               loadUse                  - hazard detected this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_match
    import riscv_pipe_pkg::*;
(
    input  logic                 exMemRead,
    input  logic [REG_IDX_W-1:0] exRd,
    input  logic [REG_IDX_W-1:0] idRs1,
    input  logic [REG_IDX_W-1:0] idRs2,
    input  logic                 idUsesRs1,
    input  logic                 idUsesRs2,
    output logic                 loadUse
);

    logic w_rs1Hit;
    logic w_rs2Hit;

    // A source only matters if the ID instruction really reads it; the
    // register field of an unused operand may hold arbitrary bits.
    assign w_rs1Hit = idUsesRs1 && (idRs1 == exRd);
    assign w_rs2Hit = idUsesRs2 && (idRs2 == exRd);

    assign loadUse = exMemRead && (exRd != REG_ZERO) && (w_rs1Hit || w_rs2Hit);

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard controller. Converts load-use hazards into
//               one-cycle bubbles, squashes wrong-path instructions after a
//               taken branch, and freezes the whole pipeline while a data
//               memory access is outstanding.
// Ports       : clk, rst (async, active high)
//               idRs1/2, idUsesRs1/2, exMemRead, exRd - hazard inputs
//               branchTaken                           - EX redirect
//               dmemReq, dmemReady                    - MEM handshake
//               pcEn, ifidEn, idexEn, exmemEn         - stage enables
//               ifidFlush, idexFlush                  - bubble insertion
//               stallCount                            - saturating stall count
//               state                                 - FSM state (debug)
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import riscv_pipe_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] idRs1,
    input  logic [REG_IDX_W-1:0] idRs2,
    input  logic                 idUsesRs1,
    input  logic                 idUsesRs2,
    input  logic                 exMemRead,
    input  logic [REG_IDX_W-1:0] exRd,
    input  logic                 branchTaken,
    input  logic                 dmemReq,
    input  logic                 dmemReady,
    output logic                 pcEn,
    output logic                 ifidEn,
    output logic                 idexEn,
    output logic                 exmemEn,
    output logic                 ifidFlush,
    output logic                 idexFlush,
    output logic [CNT_W-1:0]     stallCount,
    output logic [STATE_W-1:0]   state
);

    localparam logic [3:0]       c_FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
    localparam bit               c_MULTI_FLUSH  = (FLUSH_CYCLES > 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX      = '1;

    logic [STATE_W-1:0] r_state;
    logic [3:0]         r_flushLeft;
    logic [CNT_W-1:0]   r_stallCount;

    logic               w_loadUse;
    logic               w_freeze;
    logic [STATE_W-1:0] w_effState;
    logic [STATE_W-1:0] w_nextState;
    logic [3:0]         w_nextFlushLeft;
    logic               w_pcEn;
    logic               w_ifidEn;
    logic               w_idexEn;
    logic               w_exmemEn;
    logic               w_ifidFlush;
    logic               w_idexFlush;

    hazard_match u_match (
        .exMemRead (exMemRead),
        .exRd      (exRd),
        .idRs1     (idRs1),
        .idRs2     (idRs2),
        .idUsesRs1 (idUsesRs1),
        .idUsesRs2 (idUsesRs2),
        .loadUse   (w_loadUse)
    );

    always_comb begin
        w_freeze        = dmemReq && !dmemReady;
        w_nextState     = ST_RUN;
        w_nextFlushLeft = r_flushLeft;
        w_pcEn          = 1'b1;
        w_ifidEn        = 1'b1;
        w_idexEn        = 1'b1;
        w_exmemEn       = 1'b1;
        w_ifidFlush     = 1'b0;
        w_idexFlush     = 1'b0;

        // Leaving MEM_WAIT resumes an interrupted flush (flushLeft was held
        // through the freeze) and is evaluated in the same cycle, so a ready
        // cycle costs no extra latency.
        w_effState = r_state;
        if ((r_state == ST_MEM_WAIT) && !w_freeze) begin
            w_effState = (r_flushLeft != 4'd0) ? ST_FLUSH : ST_RUN;
        end

        if (w_freeze) begin
            w_pcEn      = 1'b0;
            w_ifidEn    = 1'b0;
            w_idexEn    = 1'b0;
            w_exmemEn   = 1'b0;
            w_nextState = ST_MEM_WAIT;
        end else if (w_effState == ST_FLUSH) begin
            // Only squashed instructions are in flight: hazards and branches
            // they appear to raise are not real.
            w_ifidFlush     = 1'b1;
            w_idexFlush     = 1'b1;
            w_nextFlushLeft = r_flushLeft - 4'd1;
            w_nextState     = (w_nextFlushLeft == 4'd0) ? ST_RUN : ST_FLUSH;
        end else if (branchTaken) begin
            // PC stays enabled so it loads the branch target this cycle
            w_ifidFlush = 1'b1;
            w_idexFlush = 1'b1;
            if (c_MULTI_FLUSH) begin
                w_nextState     = ST_FLUSH;
                w_nextFlushLeft = c_FLUSH_RELOAD;
            end
        end else if (w_loadUse) begin
            // Hold PC and IF/ID, push a bubble into ID/EX; the load itself
            // advances so the hazard is gone next cycle.
            w_pcEn      = 1'b0;
            w_ifidEn    = 1'b0;
            w_idexFlush = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_RUN;
            r_flushLeft  <= 4'd0;
            r_stallCount <= '0;
        end else begin
            r_state     <= w_nextState;
            r_flushLeft <= w_nextFlushLeft;
            if (!w_pcEn && (r_stallCount != c_CNT_MAX)) begin
                r_stallCount <= r_stallCount + 1'b1;
            end
        end
    end

    // All controls are forced inactive for as long as reset is held
    assign pcEn       = w_pcEn      && !rst;
    assign ifidEn     = w_ifidEn    && !rst;
    assign idexEn     = w_idexEn    && !rst;
    assign exmemEn    = w_exmemEn   && !rst;
    assign ifidFlush  = w_ifidFlush && !rst;
    assign idexFlush  = w_idexFlush && !rst;
    assign stallCount = r_stallCount;
    assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl. Two instances share the
//               stimulus: A (FLUSH_CYCLES=3, CNT_W=4) and B (defaults).
//               Directed table for A, hand-written saturation/reset sequence,
//               and randomized stimulus checked against a cycle model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int FC_A = 3;
    localparam int CW_A = 4;
    localparam int FC_B = 1;
    localparam int CW_B = 16;

    // {pcEn, ifidEn, idexEn, exmemEn, ifidFlush, idexFlush}
    localparam logic [5:0] NORM = 6'b111100;
    localparam logic [5:0] FRZ  = 6'b000000;
    localparam logic [5:0] FLS  = 6'b111111;
    localparam logic [5:0] LU   = 6'b001101;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] r_idRs1, r_idRs2, r_exRd;
    logic r_idUsesRs1, r_idUsesRs2, r_exMemRead, r_branchTaken, r_dmemReq, r_dmemReady;

    logic w_pcEnA, w_ifidEnA, w_idexEnA, w_exmemEnA, w_ifidFlushA, w_idexFlushA;
    logic w_pcEnB, w_ifidEnB, w_idexEnB, w_exmemEnB, w_ifidFlushB, w_idexFlushB;
    logic [CW_A-1:0] w_cntA;
    logic [CW_B-1:0] w_cntB;
    logic [1:0] w_stA, w_stB;

    always #5 clk = ~clk;

    hazard_ctrl #(.FLUSH_CYCLES(FC_A), .CNT_W(CW_A)) dutA (
        .clk(clk), .rst(rst),
        .idRs1(r_idRs1), .idRs2(r_idRs2), .idUsesRs1(r_idUsesRs1), .idUsesRs2(r_idUsesRs2),
        .exMemRead(r_exMemRead), .exRd(r_exRd), .branchTaken(r_branchTaken),
        .dmemReq(r_dmemReq), .dmemReady(r_dmemReady),
        .pcEn(w_pcEnA), .ifidEn(w_ifidEnA), .idexEn(w_idexEnA), .exmemEn(w_exmemEnA),
        .ifidFlush(w_ifidFlushA), .idexFlush(w_idexFlushA),
        .stallCount(w_cntA), .state(w_stA)
    );

    hazard_ctrl #(.FLUSH_CYCLES(FC_B), .CNT_W(CW_B)) dutB (
        .clk(clk), .rst(rst),
        .idRs1(r_idRs1), .idRs2(r_idRs2), .idUsesRs1(r_idUsesRs1), .idUsesRs2(r_idUsesRs2),
        .exMemRead(r_exMemRead), .exRd(r_exRd), .branchTaken(r_branchTaken),
        .dmemReq(r_dmemReq), .dmemReady(r_dmemReady),
        .pcEn(w_pcEnB), .ifidEn(w_ifidEnB), .idexEn(w_idexEnB), .exmemEn(w_exmemEnB),
        .ifidFlush(w_ifidFlushB), .idexFlush(w_idexFlushB),
        .stallCount(w_cntB), .state(w_stB)
    );

    int tests = 0;
    int fails = 0;

    // ---------------- reference model ----------------
    // pend   : unfrozen flush cycles still owed after the current one
    // waited : the previous edge was a frozen cycle (debug state shows 2)
    int      mPend[2];
    bit      mWaited[2];
    longint  mCnt[2];
    int      mFc[2]  = '{FC_A, FC_B};
    longint  mMax[2] = '{(64'd1 << CW_A) - 1, (64'd1 << CW_B) - 1};

    function automatic bit isFrozen();
        return r_dmemReq && !r_dmemReady;
    endfunction

    function automatic bit isLoadUse();
        return r_exMemRead && (r_exRd != 5'd0) &&
               ((r_idUsesRs1 && r_idRs1 == r_exRd) || (r_idUsesRs2 && r_idRs2 == r_exRd));
    endfunction

    function automatic logic [5:0] modelCtl(int k);
        if (isFrozen())                      return FRZ;
        if (mPend[k] > 0 || r_branchTaken)   return FLS;
        if (isLoadUse())                     return LU;
        return NORM;
    endfunction

    function automatic logic [1:0] modelSt(int k);
        if (mWaited[k]) return 2'd2;
        return (mPend[k] > 0) ? 2'd1 : 2'd0;
    endfunction

    task automatic modelEdge(int k);
        logic [5:0] ctl;
        ctl = modelCtl(k);
        if (!ctl[5] && mCnt[k] < mMax[k]) mCnt[k]++;
        if (isFrozen()) begin
            mWaited[k] = 1'b1;
        end else begin
            mWaited[k] = 1'b0;
            if (mPend[k] > 0)        mPend[k]--;
            else if (r_branchTaken)  mPend[k] = mFc[k] - 1;
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            mPend[k] = 0; mWaited[k] = 1'b0; mCnt[k] = 0;
        end
    endtask

    function automatic logic [5:0] ctlA();
        return {w_pcEnA, w_ifidEnA, w_idexEnA, w_exmemEnA, w_ifidFlushA, w_idexFlushA};
    endfunction

    function automatic logic [5:0] ctlB();
        return {w_pcEnB, w_ifidEnB, w_idexEnB, w_exmemEnB, w_ifidFlushB, w_idexFlushB};
    endfunction

    task automatic check(string nm, logic [5:0] aCtl, logic [1:0] aSt, logic [31:0] aCnt,
                         logic [5:0] eCtl, logic [1:0] eSt, logic [31:0] eCnt);
        tests++;
        if (aCtl !== eCtl || aSt !== eSt || aCnt !== eCnt) begin
            fails++;
            $display("FAIL %s @%0t: got ctl=%b st=%0d cnt=%0d, want ctl=%b st=%0d cnt=%0d",
                     nm, $time, aCtl, aSt, aCnt, eCtl, eSt, eCnt);
        end
    endtask

    task automatic setIn(logic mr, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                         logic u1, logic u2, logic br, logic req, logic rdy);
        r_exMemRead = mr; r_exRd = rd; r_idRs1 = rs1; r_idRs2 = rs2;
        r_idUsesRs1 = u1; r_idUsesRs2 = u2; r_branchTaken = br;
        r_dmemReq = req; r_dmemReady = rdy;
    endtask

    // One cycle: inputs already applied; check at negedge, model at posedge
    task automatic stepModel(string nm, bit chkA);
        @(negedge clk);
        if (chkA) check({nm, "_A"}, ctlA(), w_stA, 32'(w_cntA), modelCtl(0), modelSt(0), 32'(mCnt[0]));
        check({nm, "_B"}, ctlB(), w_stB, 32'(w_cntB), modelCtl(1), modelSt(1), 32'(mCnt[1]));
        @(posedge clk);
        modelEdge(0);
        modelEdge(1);
        #1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic       mr;
        logic [4:0] rd, rs1, rs2;
        logic       u1, u2, br, req, rdy;
        logic [5:0] ctl;
        logic [1:0] st;
        int         cnt;
    } vec_t;

    vec_t tbl[25];

    function automatic vec_t mk(logic mr, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                                logic u1, logic u2, logic br, logic req, logic rdy,
                                logic [5:0] ctl, logic [1:0] st, int cnt);
        vec_t v;
        v.mr = mr; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
        v.br = br; v.req = req; v.rdy = rdy; v.ctl = ctl; v.st = st; v.cnt = cnt;
        return v;
    endfunction

    initial begin
        // load-use, x0 and unused-source cases
        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 0);
        tbl[1]  = mk(1, 5, 5, 0, 1, 0, 0, 0, 0, LU,   0, 0);
        tbl[2]  = mk(0, 5, 5, 0, 1, 0, 0, 0, 0, NORM, 0, 1);
        tbl[3]  = mk(1, 0, 0, 0, 1, 0, 0, 0, 0, NORM, 0, 1);
        tbl[4]  = mk(1, 7, 3, 7, 1, 0, 0, 0, 0, NORM, 0, 1);
        tbl[5]  = mk(1, 7, 3, 7, 1, 1, 0, 0, 0, LU,   0, 1);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 2);
        // branch with a concurrent load-use that must be ignored
        tbl[7]  = mk(1, 5, 5, 0, 1, 0, 1, 0, 0, FLS,  0, 2);
        tbl[8]  = mk(1, 5, 5, 0, 1, 0, 0, 0, 0, FLS,  1, 2);
        tbl[9]  = mk(1, 5, 5, 0, 1, 0, 0, 0, 0, FLS,  1, 2);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 2);
        // 4-cycle freeze with branch held, flush starts in ready cycle
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, FRZ,  0, 2);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, FRZ,  2, 3);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, FRZ,  2, 4);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, FRZ,  2, 5);
        tbl[15] = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, FLS,  2, 6);
        tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, FLS,  1, 6);
        tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, FLS,  1, 6);
        tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 6);
        // freeze in the 2nd flush cycle: remaining flushes resume afterwards
        tbl[19] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, FLS,  0, 6);
        tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,  1, 6);
        tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,  2, 7);
        tbl[22] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, FLS,  2, 8);
        tbl[23] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, FLS,  1, 8);
        tbl[24] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 8);

        setIn(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        modelReset();
        repeat (2) @(posedge clk);
        #1;

        // reset values while rst is held, even with a hazard present
        setIn(1, 5, 5, 0, 1, 0, 0, 0, 0);
        @(negedge clk);
        check("reset_A", ctlA(), w_stA, 32'(w_cntA), FRZ, 2'd0, 32'd0);
        check("reset_B", ctlB(), w_stB, 32'(w_cntB), FRZ, 2'd0, 32'd0);
        setIn(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 25; i++) begin
            setIn(tbl[i].mr, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2,
                  tbl[i].br, tbl[i].req, tbl[i].rdy);
            @(negedge clk);
            check($sformatf("tbl%0d_A", i), ctlA(), w_stA, 32'(w_cntA), tbl[i].ctl, tbl[i].st, 32'(tbl[i].cnt));
            check($sformatf("tbl%0d_B", i), ctlB(), w_stB, 32'(w_cntB), modelCtl(1), modelSt(1), 32'(mCnt[1]));
            @(posedge clk);
            modelEdge(0);
            modelEdge(1);
            #1;
        end

        // 20-cycle freeze: A's 4-bit counter must stop at 15
        setIn(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 20; i++) stepModel($sformatf("sat%0d", i), 1'b1);
        @(negedge clk);
        check("sat_final_A", ctlA(), w_stA, 32'(w_cntA), FRZ, 2'd2, 32'd15);

        // asynchronous reset mid-freeze, asserted away from any clock edge
        #2;
        rst = 1'b1;
        #1;
        check("arst_now_A", ctlA(), w_stA, 32'(w_cntA), FRZ, 2'd0, 32'd0);
        check("arst_now_B", ctlB(), w_stB, 32'(w_cntB), FRZ, 2'd0, 32'd0);
        @(posedge clk);
        #1;
        check("arst_held_A", ctlA(), w_stA, 32'(w_cntA), FRZ, 2'd0, 32'd0);
        @(negedge clk);
        setIn(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        modelReset();
        #1;
        check("arst_rel_A", ctlA(), w_stA, 32'(w_cntA), NORM, 2'd0, 32'd0);
        @(posedge clk);
        #1;

        // randomized stimulus against the model
        for (int i = 0; i < 600; i++) begin
            setIn(($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) == 0), 1'($urandom));
            stepModel("rand", 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
